systolic_matmul: RTL

SYSTOLIC_MATMUL -- requirements
Module: systolic_matmul

---
 rtl/systolic_matmul_if.sv | 26 ++
 rtl/systolic_matmul.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/systolic_matmul_if.sv
// rtl/systolic_matmul_if.sv - operand/result bundle for the systolic matrix multiplier
interface systolic_matmul_if #(
    parameter int N     = 16,
    parameter int M     = 4,
    parameter int K     = 4,
    parameter int P     = 4,
    parameter int ACC_W = 2 * N + $clog2(K + 1)
);
    logic                            start;
    logic                            accumulate;
    logic [M-1:0][K-1:0][N-1:0]      a_mat;
    logic [K-1:0][P-1:0][N-1:0]      b_mat;
    logic [M-1:0][P-1:0][ACC_W-1:0]  c_mat;
    logic                            busy;
    logic                            done;

    modport master (
        output start, accumulate, a_mat, b_mat,
        input  c_mat, busy, done
    );

    modport slave (
        input  start, accumulate, a_mat, b_mat,
        output c_mat, busy, done
    );
endinterface

// File: rtl/systolic_matmul.sv
// rtl/systolic_matmul.sv - output-stationary M x P systolic grid computing C = A * B
module systolic_matmul #(
    parameter int N     = 16,
    parameter int M     = 4,
    parameter int K     = 4,
    parameter int P     = 4,
    parameter int ACC_W = 2 * N + $clog2(K + 1)
) (
    input  logic              clk,
    input  logic              rst,
    systolic_matmul_if.slave  bus
);
    // Feed counter runs 0..LAST across FEED and DRAIN; the skewed edge
    // injection needs the counter to keep going past K so lower rows and
    // right-hand columns still receive their delayed operands.  One extra
    // drain cycle covers the registered edge stage in front of the grid.
    localparam int LAST  = K + M + P - 2;
    localparam int CNT_W = $clog2(K + M + P);
    localparam int KW    = (K > 1) ? $clog2(K) : 1;

    typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               start_acc;
    logic               in_flight;

    logic [M-1:0][K-1:0][N-1:0] a_buf;
    logic [K-1:0][P-1:0][N-1:0] b_buf;

    logic signed [N-1:0] edge_a_d [M];
    logic signed [N-1:0] edge_a_q [M];
    logic signed [N-1:0] edge_b_d [P];
    logic signed [N-1:0] edge_b_q [P];

    logic signed [N-1:0]     a_in  [M][P];
    logic signed [N-1:0]     b_in  [M][P];
    logic signed [N-1:0]     a_reg [M][P];
    logic signed [N-1:0]     b_reg [M][P];
    logic signed [ACC_W-1:0] acc   [M][P];

    assign start_acc = (state_q == IDLE) && bus.start;
    assign in_flight = (state_q == FEED) || (state_q == DRAIN);
    assign bus.busy  = (state_q != IDLE);
    assign bus.done  = (state_q == DONE);

    // FSM state and feed counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: FEED for K cycles, DRAIN until the last product lands, one DONE cycle
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = FEED;
                    cnt_d   = '0;
                end
            end
            FEED: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(K - 1)) state_d = DRAIN;
            end
            DRAIN: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(LAST)) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Operand buffers capture A and B only on an accepted start
    always_ff @(posedge clk) begin
        if (rst) begin
            a_buf <= '0;
            b_buf <= '0;
        end else if (start_acc) begin
            a_buf <= bus.a_mat;
            b_buf <= bus.b_mat;
        end
    end

    // Skewed edge selection: row i gets A[i][t-i], column j gets B[t-j][j], zero outside range
    always_comb begin
        for (int i = 0; i < M; i++) begin
            edge_a_d[i] = '0;
            if (in_flight && int'(cnt_q) >= i && int'(cnt_q) - i < K)
                edge_a_d[i] = a_buf[i][KW'(int'(cnt_q) - i)];
        end
        for (int j = 0; j < P; j++) begin
            edge_b_d[j] = '0;
            if (in_flight && int'(cnt_q) >= j && int'(cnt_q) - j < K)
                edge_b_d[j] = b_buf[KW'(int'(cnt_q) - j)][j];
        end
    end

    // Edge registers that feed the left column and top row of the grid
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < M; i++) edge_a_q[i] <= '0;
            for (int j = 0; j < P; j++) edge_b_q[j] <= '0;
        end else begin
            for (int i = 0; i < M; i++) edge_a_q[i] <= edge_a_d[i];
            for (int j = 0; j < P; j++) edge_b_q[j] <= edge_b_d[j];
        end
    end

    for (genvar gi = 0; gi < M; gi++) begin : g_row
        for (genvar gj = 0; gj < P; gj++) begin : g_col
            logic signed [2*N-1:0] a_ext, b_ext, prod;

            if (gj == 0) begin : g_a_edge
                assign a_in[gi][gj] = edge_a_q[gi];
            end else begin : g_a_pass
                assign a_in[gi][gj] = a_reg[gi][gj-1];
            end

            if (gi == 0) begin : g_b_edge
                assign b_in[gi][gj] = edge_b_q[gj];
            end else begin : g_b_pass
                assign b_in[gi][gj] = b_reg[gi-1][gj];
            end

            assign a_ext = (2 * N)'(a_in[gi][gj]);
            assign b_ext = (2 * N)'(b_in[gi][gj]);
            assign prod  = a_ext * b_ext;

            // MAC cell: pass operands on, clear or keep the sum on start, add the sign-extended product
            always_ff @(posedge clk) begin
                if (rst) begin
                    a_reg[gi][gj] <= '0;
                    b_reg[gi][gj] <= '0;
                    acc[gi][gj]   <= '0;
                end else begin
                    a_reg[gi][gj] <= a_in[gi][gj];
                    b_reg[gi][gj] <= b_in[gi][gj];
                    if (start_acc && !bus.accumulate)
                        acc[gi][gj] <= '0;
                    else
                        acc[gi][gj] <= acc[gi][gj] + ACC_W'(prod);
                end
            end
        end
    end

    // Result matrix is the live accumulator array
    always_comb begin
        for (int i = 0; i < M; i++)
            for (int j = 0; j < P; j++)
                bus.c_mat[i][j] = acc[i][j];
    end
endmodule
